// File: rtl/muldiv_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int MD_WIDTH = 32;
    localparam int CNT_W    = $clog2(MD_WIDTH + 1);

endpackage

// File: rtl/muldiv_datapath.sv
// Iteration registers: radix-2 shift-add multiply and restoring divide on magnitudes.
module muldiv_datapath #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  iterate,
    input  logic                  is_div,
    input  logic [DATA_WIDTH-1:0] a_mag,
    input  logic [DATA_WIDTH-1:0] b_mag,
    output logic [DATA_WIDTH-1:0] acc,
    output logic [DATA_WIDTH-1:0] sreg,
    output logic                  last
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    logic [W-1:0]  breg;
    logic [CW-1:0] count;
    logic [W:0]    add_sum;
    logic [W:0]    rem_sh;
    logic [W:0]    diff;

    // Multiply: acc:sreg is the product, multiplier bits consumed from sreg[0].
    // Divide: sreg shifts the dividend out and the quotient in; acc is the partial remainder.
    always_comb begin
        add_sum = {1'b0, acc} + (sreg[0] ? {1'b0, breg} : '0);
        rem_sh  = {acc, sreg[W-1]};
        diff    = rem_sh - {1'b0, breg};
    end

    assign last = (count == CW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            acc   <= '0;
            sreg  <= '0;
            breg  <= '0;
            count <= '0;
        end else if (load) begin
            acc   <= '0;
            sreg  <= a_mag;
            breg  <= b_mag;
            count <= CW'(W);
        end else if (iterate) begin
            count <= count - 1'b1;
            if (is_div) begin
                if (!diff[W]) begin
                    acc  <= diff[W-1:0];
                    sreg <= {sreg[W-2:0], 1'b1};
                end else begin
                    acc  <= rem_sh[W-1:0];
                    sreg <= {sreg[W-2:0], 1'b0};
                end
            end else begin
                acc  <= add_sum[W:1];
                sreg <= {add_sum[0], sreg[W-1:1]};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multi-cycle multiply/divide unit: FSM, sign handling, special cases and result select.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH    = MD_WIDTH,
    parameter int OPCODE_LENGTH = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    output logic                     busy,
    output logic                     ResultValid,
    output logic [DATA_WIDTH-1:0]    Result
);
    localparam int W = DATA_WIDTH;

    state_t       state, state_next;
    op_t          op_in, op_q;
    logic         a_neg, b_neg, div_zero, div_ovf, accept;
    logic         load, iterate, last;
    logic         spec_q, neg_q, rem_neg_q;
    logic [W-1:0] a_mag, b_mag, spec_val, spec_res_q;
    logic [W-1:0] acc, sreg, quo, rem, done_val;
    logic [2*W-1:0] prod;

    always_comb begin
        op_in    = op_t'(Operation[2:0]);
        a_neg    = (op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && SrcA[W-1];
        b_neg    = (op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM}) && SrcB[W-1];
        a_mag    = a_neg ? -SrcA : SrcA;
        b_mag    = b_neg ? -SrcB : SrcB;
        div_zero = Operation[2] && (SrcB == '0);
        div_ovf  = (op_in inside {OP_DIV, OP_REM}) && (SrcA == {1'b1, {(W-1){1'b0}}}) && (SrcB == '1);
        if (div_zero) spec_val = Operation[1] ? SrcA : '1;
        else          spec_val = Operation[1] ? '0 : SrcA;
    end

    // A start coinciding with ResultValid is deliberately dropped.
    assign accept = start && !ResultValid;
    assign busy   = (state != IDLE);

    always_comb begin
        state_next = state;
        load       = 1'b0;
        iterate    = 1'b0;
        case (state)
            IDLE: if (accept) begin
                if (div_zero || div_ovf) begin
                    state_next = DONE;
                end else begin
                    load       = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                iterate = 1'b1;
                if (last) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && accept) begin
            op_q       <= op_in;
            neg_q      <= a_neg ^ b_neg;
            rem_neg_q  <= a_neg;
            spec_q     <= div_zero || div_ovf;
            spec_res_q <= spec_val;
        end
    end

    muldiv_datapath #(.DATA_WIDTH(W)) u_datapath (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .iterate (iterate),
        .is_div  (op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}),
        .a_mag   (a_mag),
        .b_mag   (b_mag),
        .acc     (acc),
        .sreg    (sreg),
        .last    (last)
    );

    always_comb begin
        prod = neg_q ? -{acc, sreg} : {acc, sreg};
        quo  = neg_q ? -sreg : sreg;
        rem  = rem_neg_q ? -acc : acc;
        case (op_q)
            OP_MUL:                       done_val = prod[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: done_val = prod[2*W-1:W];
            OP_DIV, OP_DIVU:              done_val = quo;
            default:                      done_val = rem;
        endcase
        if (spec_q) done_val = spec_res_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ResultValid <= 1'b0;
            Result      <= '0;
        end else begin
            ResultValid <= (state == DONE);
            if (state == DONE) Result <= done_val;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized + directed bench for muldiv_unit against a plain-arithmetic RV32M model.
module tb_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   Operation = 3'd0;
    logic [W-1:0] SrcA = '0;
    logic [W-1:0] SrcB = '0;
    logic         busy;
    logic         ResultValid;
    logic [W-1:0] Result;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    muldiv_unit #(.DATA_WIDTH(W), .OPCODE_LENGTH(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .Operation   (Operation),
        .SrcA        (SrcA),
        .SrcB        (SrcB),
        .busy        (busy),
        .ResultValid (ResultValid),
        .Result      (Result)
    );

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      pa, pb;
        logic [63:0] p;
        int          sa, sb;
        logic [31:0] r;
        sa = a;
        sb = b;
        p  = {32'd0, a} * {32'd0, b};
        case (op)
            3'd0: r = p[31:0];
            3'd1: begin pa = sa; pb = sb; p = pa * pb; r = p[63:32]; end
            3'd2: begin pa = sa; pb = {32'd0, b}; p = pa * pb; r = p[63:32]; end
            3'd3: r = p[63:32];
            3'd4: if (b == 0) r = '1;
                  else if (a == 32'h8000_0000 && b == '1) r = a;
                  else r = sa / sb;
            3'd5: r = (b == 0) ? '1 : a / b;
            3'd6: if (b == 0) r = a;
                  else if (a == 32'h8000_0000 && b == '1) r = 0;
                  else r = sa % sb;
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == '1))) return 2;
        return W + 2;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!reset && ResultValid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got Result=%h expected no ResultValid", Result);
            end else begin
                e = exp_q.pop_front();
                if (Result !== e || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL model_result: got Result=%h busy=%b expected %h busy=0", Result, busy, e);
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy || ResultValid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        start     = 1'b1;
        exp_q.push_back(model(op, a, b));
        @(negedge clk);
        start     = 1'b0;
        SrcA      = $urandom();
        SrcB      = $urandom();
        Operation = 3'($urandom_range(0, 7));
    endtask

    task automatic collect(input int lat0, output logic [31:0] r, output int lat, output int bcnt);
        lat  = lat0;
        bcnt = 0;
        while (1) begin
            if (busy) bcnt++;
            if (ResultValid) break;
            if (lat >= 200) begin
                check("valid_timeout", 32'd1, 32'd0);
                break;
            end
            @(negedge clk);
            lat++;
        end
        r = Result;
    endtask

    task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output int lat, output int bcnt);
        wait_idle();
        issue(op, a, b);
        collect(1, r, lat, bcnt);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r, a, b;
        logic [2:0]  op;
        int          lat, bcnt, sel;

        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_valid", 32'(ResultValid), 32'd0);
        check("reset_result", Result, 32'd0);
        reset = 1'b0;

        run(3'd0, 32'd7, 32'hFFFF_FFFD, r, lat, bcnt);
        check("mul_7_m3", r, 32'hFFFF_FFEB);
        check("mul_latency", 32'(lat), 32'd34);
        check("mul_busy_cycles", 32'(bcnt), 32'd33);

        run(3'd1, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, bcnt); check("mulh", r, 32'h0000_0000);
        run(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, bcnt); check("mulhsu", r, 32'h8000_0000);
        run(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, bcnt); check("mulhu", r, 32'h7FFF_FFFF);
        run(3'd4, -32'sd7, 32'd2, r, lat, bcnt);   check("div_m7_2", r, 32'hFFFF_FFFD);
        run(3'd6, -32'sd7, 32'd2, r, lat, bcnt);   check("rem_m7_2", r, 32'hFFFF_FFFF);
        run(3'd5, 32'd100, 32'd7, r, lat, bcnt);   check("divu_100_7", r, 32'd14);
        run(3'd7, 32'd100, 32'd7, r, lat, bcnt);   check("remu_100_7", r, 32'd2);
        check("div_latency", 32'(lat), 32'd34);

        run(3'd5, 32'd5, 32'd0, r, lat, bcnt);
        check("divu_by_zero", r, 32'hFFFF_FFFF); check("divu_by_zero_lat", 32'(lat), 32'd2);
        run(3'd6, 32'd5, 32'd0, r, lat, bcnt);
        check("rem_by_zero", r, 32'd5); check("rem_by_zero_lat", 32'(lat), 32'd2);
        run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, bcnt);
        check("div_overflow", r, 32'h8000_0000); check("div_overflow_lat", 32'(lat), 32'd2);
        run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, bcnt);
        check("rem_overflow", r, 32'd0); check("rem_overflow_lat", 32'(lat), 32'd2);

        // start held through the ResultValid cycle: only the following IDLE cycle accepts it
        Operation = 3'd3; SrcA = 32'hDEAD_BEEF; SrcB = 32'h1234_5678; start = 1'b1;
        exp_q.push_back(model(3'd3, 32'hDEAD_BEEF, 32'h1234_5678));
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        collect(2, r, lat, bcnt);
        check("start_during_valid_lat", 32'(lat), 32'd35);

        // second start mid-operation must be ignored
        wait_idle();
        issue(3'd0, 32'h0000_1234, 32'h0000_5678);
        repeat (8) @(negedge clk);
        Operation = 3'd4; SrcA = 32'd100; SrcB = 32'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        collect(10, r, lat, bcnt);
        check("busy_start_ignored", r, 32'h0626_0060);
        check("busy_start_lat", 32'(lat), 32'd34);
        repeat (40) @(negedge clk);

        // reset mid-divide aborts it
        wait_idle();
        issue(3'd4, 32'd1000, 32'd7);
        repeat (13) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(ResultValid), 32'd0);
        check("abort_result", Result, 32'd0);
        repeat (45) @(negedge clk);
        run(3'd0, 32'd3, 32'd4, r, lat, bcnt);
        check("mul_after_abort", r, 32'd12);

        for (int i = 0; i < 250; i++) begin
            op  = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 9);
            a   = $urandom();
            b   = $urandom();
            case (sel)
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
                3: begin a = -$urandom_range(0, 300); b = $urandom_range(1, 20); end
                4: begin a = $urandom_range(0, 300); b = -$urandom_range(1, 20); end
                default: ;
            endcase
            run(op, a, b, r, lat, bcnt);
            check("rand_latency", 32'(lat), 32'(exp_latency(op, a, b)));
        end

        wait_idle();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
